// File: rtl/maxpool_arbiter_pkg.sv
// Shared types for the maxpool engine and the requester arbiter in front of it.
package maxpool_arbiter_pkg;

    // Engine-side sequencing states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW1,
        S_OUT
    } state_t;

    // Arbiter job states: two rows in, one settle cycle, one result out.
    typedef enum logic [2:0] {
        A_IDLE,
        A_ROW0,
        A_ROW1,
        A_SETTLE,
        A_DRAIN
    } arb_state_t;

    localparam int ARB_ROWS_PER_JOB = 2;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/maxpool_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module maxpool_arbiter_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] cand [N];

    // cand[k] is the requester k places after ptr, modulo N.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IDW:0] sum;
        assign sum = {1'b0, ptr} + (IDW+1)'(gi);
        assign cand[gi] = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
    end

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/maxpool_arbiter.sv
// Shares one 2-row maxpool engine between N requesters with round-robin, job-atomic grants.
module maxpool_arbiter
    import maxpool_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int R   = 10,
    parameter int W   = 8,
    parameter int IDW = $clog2(N),
    parameter int CW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         s_valid,
    output logic [N-1:0]         s_ready,
    input  logic [N*R*W-1:0]     s_data,
    output logic [N-1:0]         m_valid,
    input  logic [N-1:0]         m_ready,
    output logic [(R/2)*W-1:0]   m_data,
    output logic [IDW-1:0]       m_id,
    output logic                 e_s_valid,
    input  logic                 e_s_ready,
    output logic [R*W-1:0]       e_s_data,
    input  logic                 e_m_valid,
    output logic                 e_m_ready,
    input  logic [(R/2)*W-1:0]   e_m_data,
    output logic                 busy,
    output logic [CW-1:0]        jobs_done
);

    arb_state_t     state_reg, state_next;
    logic [IDW-1:0] grant_reg, grant_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [CW-1:0]  jobs_reg, jobs_next;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;

    logic [R*W-1:0] row_data [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rows
        assign row_data[gi] = s_data[gi*R*W +: R*W];
    end

    maxpool_arbiter_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) rr_pick (
        .req (s_valid),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= A_IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            jobs_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            jobs_reg  <= jobs_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        jobs_next  = jobs_reg;
        s_ready    = '0;
        m_valid    = '0;
        e_s_valid  = 1'b0;
        e_m_ready  = 1'b1;

        case (state_reg)
            A_IDLE: begin
                if (pick_any) begin
                    grant_next = pick_idx;
                    state_next = A_ROW0;
                end
            end
            A_ROW0, A_ROW1: begin
                e_s_valid          = s_valid[grant_reg];
                s_ready[grant_reg] = e_s_ready;
                if (s_valid[grant_reg] && e_s_ready) begin
                    state_next = (state_reg == A_ROW0) ? A_ROW1 : A_SETTLE;
                end
            end
            A_SETTLE: begin
                // Engine output register is loaded one cycle after e_m_valid rises.
                e_m_ready  = 1'b0;
                state_next = A_DRAIN;
            end
            A_DRAIN: begin
                m_valid[grant_reg] = e_m_valid;
                e_m_ready          = m_ready[grant_reg];
                if (e_m_valid && m_ready[grant_reg]) begin
                    jobs_next  = jobs_reg + CW'(1);
                    ptr_next   = IDW'(wrap_inc(32'(grant_reg), N));
                    state_next = A_IDLE;
                end
            end
            default: state_next = A_IDLE;
        endcase
    end

    assign e_s_data  = row_data[grant_reg];
    assign m_data    = e_m_data;
    assign m_id      = grant_reg;
    assign busy      = (state_reg != A_IDLE);
    assign jobs_done = jobs_reg;

endmodule
